tx_scheduler: RTL and testbench
===============================

TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the UART transmitter; legal range 2..8.
REQ-002 Parameter DATA_WIDTH, default 8, byte width per requester.
REQ-003 Parameter CLKS_PER_BIT, default 16, clocks per serial bit of the downstream transmitter.
REQ-004 Parameter BITS_PER_FRAME, default 10, serial bits per frame (start + data + stop).
REQ-005 Parameter GAP_CYCLES, default 8, idle guard cycles between frames; used only when TX_SCHED_GAP_EN is defined.
REQ-006 Block SHALL have one clock; reset is asynchronous and active-high.
REQ-007 clk  input  1  system clock, all state on rising edge.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 req  input  N_REQ  level request per requester.
REQ-010 req_data  input  N_REQ*DATA_WIDTH  flat byte bus; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 gnt  output  N_REQ  one-hot, one-cycle grant; byte accepted.
REQ-012 send  output  1  one-cycle start pulse to transmitter state_machine.
REQ-013 data  output  DATA_WIDTH  byte to transmitter, stable from send until frame end.
REQ-014 busy  output  1  high while a frame is in flight (any state except IDLE).
REQ-015 grant_id  output  $clog2(N_REQ)  index of last granted requester.

Function
REQ-016 FSM states SHALL be IDLE, SEND, WAIT, GAP; GAP exists only under TX_SCHED_GAP_EN.
REQ-017 IDLE: req sampled only here; if |req at edge k, winner registered, next cycle (after edge k) state=SEND.
REQ-018 SEND lasts exactly one cycle: gnt[winner]=1, send=1, data=req_data[winner] captured at edge k, grant_id=winner.
REQ-019 WAIT SHALL last exactly FRAME_CYCLES = CLKS_PER_BIT*BITS_PER_FRAME cycles via down-counter, width $clog2(FRAME_CYCLES+1).
REQ-020 WAIT exit: to GAP (macro defined) else IDLE; GAP lasts GAP_CYCLES, then IDLE.
REQ-021 Arbitration SHALL be round-robin: search starts at grant_id+1 modulo N_REQ, wrapping; after reset search starts at 0.
REQ-022 Minimum send-to-send spacing SHALL be FRAME_CYCLES+2 cycles (no GAP) or FRAME_CYCLES+GAP_CYCLES+2 (with GAP).
REQ-023 req changes outside IDLE SHALL be ignored; a requester still high after its gnt is re-arbitrated normally (no starvation of others).
REQ-024 data SHALL hold its value through WAIT/GAP and until the next SEND.
REQ-025 send and gnt SHALL never be high outside SEND; gnt SHALL have at most one bit set.

Reset
REQ-026 rst SHALL immediately force: state IDLE, send 0, gnt 0, busy 0, data 0, grant_id N_REQ-1, counter 0.
REQ-027 rst mid-frame SHALL abort the frame; no gnt or send SHALL be issued for the aborted arbitration; first request after deassert wins from index 0.

Configuration
REQ-028 Macro TX_SCHED_GAP_EN: defined -> GAP state and GAP_CYCLES guard inserted after every frame, busy high during GAP; undefined -> WAIT returns directly to IDLE and GAP logic is absent.

Structure
REQ-029 Package tx_sched_pkg SHALL hold the state typedef (IDLE, SEND, WAIT, GAP) and default constants for CLKS_PER_BIT and BITS_PER_FRAME.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, last index; outputs one-hot winner, index, valid), purely combinational.

Verification (N_REQ=4, CLKS_PER_BIT=4, BITS_PER_FRAME=10, FRAME_CYCLES=40)
REQ-031 Single request: req=4'b0100, byte 8'hA5 -> one cycle later gnt=4'b0100, send=1, data=8'hA5, grant_id=2; busy high 41 cycles.
REQ-032 All requesting, bytes 8'h10..8'h13 held -> grants in order 0,1,2,3,0 with send pulses exactly 42 cycles apart.
REQ-033 req=4'b1001 after grant to 3 -> next grant to 0; after grant to 0 -> next grant to 3.
REQ-034 Change req_data during WAIT -> data unchanged; no extra gnt or send.
REQ-035 rst asserted 20 cycles into WAIT -> busy, send, gnt, data drop to 0 without waiting for edge; after release req=4'b1111 -> gnt=4'b0001.
REQ-036 TX_SCHED_GAP_EN defined, GAP_CYCLES=8, continuous requests -> send spacing 50 cycles; busy stays high through GAP.

Source files
------------

// File: rtl/tx_sched_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
// The FSM encoding includes GAP even when TX_SCHED_GAP_EN is undefined.
// Keeping the encoding fixed means every build uses the same state values.
package tx_sched_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SEND = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_GAP  = 2'd3;

  // Default serial framing of the downstream transmitter
  localparam int CLKS_PER_BIT_DEF   = 16;
  localparam int BITS_PER_FRAME_DEF = 10;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search for a requester starts one position after the last granted
// index and wraps around, so the last winner has the lowest priority.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     valid
);

  localparam int IW = $clog2(N_REQ);

  int cand;

  // Scan from farthest to nearest offset; the nearest hit overwrites the rest
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int off = N_REQ; off >= 1; off--) begin
      cand = (int'(last) + off) % N_REQ;
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand[IW-1:0];
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_scheduler.sv
// Round-robin scheduler that shares one UART transmitter between N_REQ
// byte requesters.
// The IDLE state picks a winner and registers it. SEND issues gnt and send
// for one cycle. WAIT counts down one frame time. When TX_SCHED_GAP_EN is
// defined, an idle GAP of GAP_CYCLES follows every frame.
// The macro TX_SCHED_GAP_EN enables that gap.
module tx_scheduler
  import tx_sched_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int CLKS_PER_BIT   = CLKS_PER_BIT_DEF,
  parameter int BITS_PER_FRAME = BITS_PER_FRAME_DEF,
  parameter int GAP_CYCLES     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            gnt,
  output logic                        send,
  output logic [DATA_WIDTH-1:0]       data,
  output logic                        busy,
  output logic [$clog2(N_REQ)-1:0]    grant_id
);

  localparam int IW           = $clog2(N_REQ);
  localparam int FRAME_CYCLES = CLKS_PER_BIT * BITS_PER_FRAME;
  // The counter is shared by WAIT and GAP, so size it for the longer one
  localparam int CNT_MAX      = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
  localparam int CW           = $clog2(CNT_MAX + 1);

  state_t                  state_reg;
  logic [CW-1:0]           cnt_reg;
  logic [N_REQ-1:0]        gnt_reg;
  logic                    send_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic [IW-1:0]           grant_id_reg;

  logic [N_REQ-1:0]        win_onehot;
  logic [IW-1:0]           win_idx;
  logic                    win_valid;
  logic [DATA_WIDTH-1:0]   req_bytes [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_bytes
      assign req_bytes[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (req),
    .last  (grant_id_reg),
    .grant (win_onehot),
    .idx   (win_idx),
    .valid (win_valid)
  );

  // Frame sequencing: arbitrate in IDLE, pulse in SEND, time the frame out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      gnt_reg      <= '0;
      send_reg     <= 1'b0;
      data_reg     <= '0;
      grant_id_reg <= IW'(N_REQ - 1);
    end else begin
      gnt_reg  <= '0;
      send_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (win_valid) begin
            gnt_reg      <= win_onehot;
            send_reg     <= 1'b1;
            data_reg     <= req_bytes[win_idx];
            grant_id_reg <= win_idx;
            state_reg    <= ST_SEND;
          end
        end
        ST_SEND: begin
          cnt_reg   <= CW'(FRAME_CYCLES);
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_reg == CW'(1)) begin
`ifdef TX_SCHED_GAP_EN
            cnt_reg   <= CW'(GAP_CYCLES);
            state_reg <= ST_GAP;
`else
            cnt_reg   <= '0;
            state_reg <= ST_IDLE;
`endif
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
`ifdef TX_SCHED_GAP_EN
        ST_GAP: begin
          if (cnt_reg == CW'(1)) begin
            cnt_reg   <= '0;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
`endif
        default: begin
          cnt_reg   <= '0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt      = gnt_reg;
  assign send     = send_reg;
  assign data     = data_reg;
  assign grant_id = grant_id_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler. It applies a table of arbitration
// vectors, then hand-written sequences for back-to-back frames, ignored
// inputs during WAIT, and reset in the middle of a frame.
module tb_tx_scheduler;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int CPB   = 4;
  localparam int BPF   = 10;
  localparam int GAP   = 8;
  localparam int FRAME = CPB * BPF;
`ifdef TX_SCHED_GAP_EN
  localparam int SPACING  = FRAME + GAP + 2;
  localparam int BUSY_LEN = FRAME + GAP + 1;
`else
  localparam int SPACING  = FRAME + 2;
  localparam int BUSY_LEN = FRAME + 1;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    gnt;
  logic            send;
  logic [DW-1:0]   data;
  logic            busy;
  logic [1:0]      grant_id;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  tx_scheduler #(
    .N_REQ(N), .DATA_WIDTH(DW), .CLKS_PER_BIT(CPB),
    .BITS_PER_FRAME(BPF), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .send(send), .data(data), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Protocol invariants on every cycle out of reset
  always @(negedge clk) begin
    if (!rst) begin
      if ((gnt != '0) && !send) viol++;
      if (send && (gnt == '0)) viol++;
      if ($countones(gnt) > 1) viol++;
    end
  end

  typedef struct {
    logic [N-1:0]    req;
    logic [N*DW-1:0] rdata;
    logic [N-1:0]    gnt;
    logic [1:0]      id;
    logic [DW-1:0]   data;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 200 && busy; c++) @(negedge clk);
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  int len;
  int gap_cnt;
  int extra;

  initial begin
    vecs[0] = '{4'b0100, 32'h44A52211, 4'b0100, 2'd2, 8'hA5};
    vecs[1] = '{4'b1111, 32'h13121110, 4'b1000, 2'd3, 8'h13};
    vecs[2] = '{4'b1001, 32'h13121110, 4'b0001, 2'd0, 8'h10};
    vecs[3] = '{4'b1001, 32'h13121110, 4'b1000, 2'd3, 8'h13};
    vecs[4] = '{4'b0011, 32'h13121110, 4'b0001, 2'd0, 8'h10};
    vecs[5] = '{4'b0001, 32'h13121110, 4'b0001, 2'd0, 8'h10};
    vecs[6] = '{4'b0110, 32'h13121110, 4'b0010, 2'd1, 8'h11};
    vecs[7] = '{4'b1100, 32'hDEADBEEF, 4'b0100, 2'd2, 8'hAD};

    // Reset state
    @(negedge clk);
    check("rst_send", {31'd0, send}, 32'd0);
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_grant_id", {30'd0, grant_id}, 32'd3);
    rst = 1'b0;

    // Table-driven arbitration vectors
    for (int i = 0; i < 8; i++) begin
      wait_idle();
      req      = vecs[i].req;
      req_data = vecs[i].rdata;
      @(negedge clk);
      req = '0;
      check("vec_send", {31'd0, send}, 32'd1);
      check("vec_gnt", {28'd0, gnt}, {28'd0, vecs[i].gnt});
      check("vec_grant_id", {30'd0, grant_id}, {30'd0, vecs[i].id});
      check("vec_data", {24'd0, data}, {24'd0, vecs[i].data});
      $display("vec %0d req=%b gnt=%b id=%0d data=%h", i, vecs[i].req, gnt, grant_id, data);
      if (i == 0) begin
        len = 0;
        for (int c = 0; c < 200 && busy; c++) begin
          len++;
          @(negedge clk);
        end
        check("busy_len", len, BUSY_LEN);
      end
    end
    wait_idle();

    // Continuous requests after reset: 0,1,2,3,0 at fixed spacing
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    req      = 4'b1111;
    req_data = 32'h13121110;
    for (int k = 0; k < 5; k++) begin
      gap_cnt = 0;
      do begin
        @(negedge clk);
        gap_cnt++;
      end while (!send && gap_cnt < 200);
      check("rr_send", {31'd0, send}, 32'd1);
      check("rr_grant_id", {30'd0, grant_id}, k % 4);
      check("rr_gnt", {28'd0, gnt}, 32'd1 << (k % 4));
      check("rr_data", {24'd0, data}, 32'h10 + (k % 4));
      if (k > 0) check("rr_spacing", gap_cnt, SPACING);
      $display("burst %0d id=%0d gnt=%b data=%h spacing=%0d", k, grant_id, gnt, data, gap_cnt);
    end
    req = '0;
    wait_idle();

    // Inputs that change during WAIT have no effect
    req      = 4'b0001;
    req_data = 32'h13121110;
    @(negedge clk);
    check("hold_send", {31'd0, send}, 32'd1);
    req      = 4'b1111;
    req_data = 32'hFFEEDDCC;
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (send || gnt != '0) extra++;
    end
    check("hold_data", {24'd0, data}, 32'h10);
    check("hold_no_extra", extra, 0);
    req = '0;
    wait_idle();
    @(negedge clk);
    check("hold_idle_send", {31'd0, send}, 32'd0);
    check("hold_idle_data", {24'd0, data}, 32'h10);
    $display("hold data=%h extra=%0d", data, extra);

    // Reset in the middle of WAIT aborts the frame immediately
    req      = 4'b0100;
    req_data = 32'h005A0000;
    @(negedge clk);
    req = '0;
    check("abort_pre_data", {24'd0, data}, 32'h5A);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_send", {31'd0, send}, 32'd0);
    check("abort_gnt", {28'd0, gnt}, 32'd0);
    check("abort_data", {24'd0, data}, 32'd0);
    check("abort_grant_id", {30'd0, grant_id}, 32'd3);
    @(negedge clk);
    rst      = 1'b0;
    req      = 4'b1111;
    req_data = 32'h44332211;
    @(negedge clk);
    req = '0;
    check("post_rst_gnt", {28'd0, gnt}, 32'd1);
    check("post_rst_data", {24'd0, data}, 32'h11);
    check("post_rst_id", {30'd0, grant_id}, 32'd0);
    $display("abort then grant gnt=%b id=%0d data=%h", gnt, grant_id, data);
    wait_idle();

    check("protocol_violations", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
